// File: rtl/f_sweep_pkg.sv
// Shared types and constants for the gate-f sweep checker.
// Gate f truth table: bit m = f(A,B,C,D) with m = {A,B,C,D}.
package f_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int          VEC_COUNT  = 16;
  localparam int          IDX_W      = 4;
  localparam logic [15:0] F_EXPECTED = 16'hFE51;

endpackage

// File: rtl/f_sweep_checker_settle_timer.sv
// Loadable down-counter; zero flags the end of the settle dwell.
// Holds at zero until the next load.
module settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/f_sweep_checker.sv
// Sweeps all 16 vectors into gate f, captures its truth-table
// signature and scores it against EXPECTED.
module f_sweep_checker
  import f_sweep_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = F_EXPECTED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        a_o,
  output logic        b_o,
  output logic        c_o,
  output logic        d_o,
  input  logic        f_i,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail_idx,
  output logic        fail_valid
);

  localparam int CNT_W =
    (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LD =
    CNT_W'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(VEC_COUNT - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] stim;
  logic             accept;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_zero;
  logic             smp_bit;
  logic             smp_miss;

  assign accept   = (state == IDLE) && start && !abort;
  assign tmr_load = accept ||
                    (state == SAMPLE && !abort && idx != LAST_IDX);
  assign tmr_dec  = (state == SETTLE) && !tmr_zero;

  // X or Z on the gate output counts as a 0
  assign smp_bit  = (f_i === 1'b1);
  assign smp_miss = (smp_bit != EXPECTED[idx]);

  assign {a_o, b_o, c_o, d_o} = stim;

  settle_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_LD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      stim           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      signature      <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      fail_valid     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            signature      <= '0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            fail_valid     <= 1'b0;
            pass           <= 1'b0;
            idx            <= '0;
            stim           <= '0;
            busy           <= 1'b1;
            state          <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            stim  <= '0;
            pass  <= 1'b0;
          end else if (tmr_zero) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            stim  <= '0;
            pass  <= 1'b0;
          end else begin
            signature[idx] <= smp_bit;
            if (smp_miss) begin
              mismatch_cnt <= mismatch_cnt + 5'd1;
              if (!fail_valid) begin
                first_fail_idx <= idx;
                fail_valid     <= 1'b1;
              end
            end
            if (idx == LAST_IDX) begin
              state <= DONE;
              busy  <= 1'b0;
              stim  <= '0;
            end else begin
              idx   <= idx + 1'b1;
              stim  <= idx + 1'b1;
              state <= SETTLE;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          pass  <= (signature == EXPECTED);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f_sweep_checker.sv
// Bench for f_sweep_checker: gate f modelled as a truth table,
// sweep results scored by a whole-table reference model.
module tb_f_sweep_checker;

  localparam logic [15:0] GOOD = 16'hFE51;

  typedef struct {
    logic [15:0] gt;
    logic [15:0] sig;
    int          cnt;
    int          ffi;
    logic        fv;
    logic        pas;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        start [2];
  logic        abort [2];
  logic        a [2];
  logic        b [2];
  logic        c [2];
  logic        d [2];
  logic        f [2];
  logic        busy [2];
  logic        done [2];
  logic        pass [2];
  logic [15:0] sig [2];
  logic [4:0]  mcnt [2];
  logic [3:0]  ffi [2];
  logic        fv [2];
  logic [15:0] gt [2];
  logic [3:0]  stim [2];

  int checks = 0;
  int errors = 0;

  for (genvar u = 0; u < 2; u++) begin : g_gate
    assign stim[u] = {a[u], b[u], c[u], d[u]};
    assign f[u]    = gt[u][stim[u]];
  end

  f_sweep_checker #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .start(start[0]), .abort(abort[0]),
    .a_o(a[0]), .b_o(b[0]), .c_o(c[0]), .d_o(d[0]),
    .f_i(f[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .signature(sig[0]),
    .mismatch_cnt(mcnt[0]), .first_fail_idx(ffi[0]),
    .fail_valid(fv[0])
  );

  f_sweep_checker #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .start(start[1]), .abort(abort[1]),
    .a_o(a[1]), .b_o(b[1]), .c_o(c[1]), .d_o(d[1]),
    .f_i(f[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .signature(sig[1]),
    .mismatch_cnt(mcnt[1]), .first_fail_idx(ffi[1]),
    .fail_valid(fv[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Sampling vector m reads the gate's response to m, so the
  // ideal signature is the gate's own truth table.
  function automatic vec_t model(input logic [15:0] g);
    vec_t        v;
    logic [15:0] e;
    e     = GOOD;
    v.gt  = g;
    v.sig = g;
    v.cnt = 0;
    v.ffi = 0;
    v.fv  = 1'b0;
    for (int m = 0; m < 16; m++) begin
      if (g[m] != e[m]) begin
        if (!v.fv) v.ffi = m;
        v.fv = 1'b1;
        v.cnt++;
      end
    end
    v.pas = (g == e);
    return v;
  endfunction

  task automatic outs_zero(input int u, input string tag);
    chk(tag, 32'({busy[u], done[u], pass[u], fv[u],
                  sig[u], mcnt[u], ffi[u], stim[u]}), 32'd0);
    chk({tag, "_sig"}, 32'(sig[u]), 32'd0);
  endtask

  task automatic run_sweep(input int u, input vec_t v,
                           input int extra, input string tag);
    int lat;
    int exp_lat;
    int q[$];
    logic ok;
    exp_lat = (u == 0) ? 16 * (2 + 2) + 1 : 16 * (0 + 2) + 1;
    gt[u] = v.gt;
    @(negedge clk) start[u] = 1'b1;
    @(negedge clk) start[u] = 1'b0;
    lat = 0;
    while (!done[u] && lat < 300) begin
      if (busy[u] && (q.size() == 0 || q[$] != int'(stim[u])))
        q.push_back(int'(stim[u]));
      @(negedge clk);
      lat++;
      start[u] = (lat == extra);
    end
    start[u] = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_sig"}, 32'(sig[u]), 32'(v.sig));
    chk({tag, "_mcnt"}, 32'(mcnt[u]), 32'(v.cnt));
    chk({tag, "_ffi"}, 32'(ffi[u]), 32'(v.ffi));
    chk({tag, "_fv"}, 32'(fv[u]), 32'(v.fv));
    chk({tag, "_pass"}, 32'(pass[u]), 32'(v.pas));
    chk({tag, "_idle"}, 32'({busy[u], stim[u]}), 32'd0);
    ok = (q.size() == 16);
    foreach (q[i]) if (q[i] != i) ok = 1'b0;
    chk({tag, "_stim_order"}, 32'(ok), 32'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done[u]), 32'd0);
    chk({tag, "_pass_hold"}, 32'(pass[u]), 32'(v.pas));
  endtask

  vec_t vq[$];

  initial begin
    vec_t v;
    logic ok;
    vq.push_back('{16'hFE51, 16'hFE51, 0,  0, 1'b0, 1'b1});
    vq.push_back('{16'h0000, 16'h0000, 10, 0, 1'b1, 1'b0});
    vq.push_back('{16'h01AE, 16'h01AE, 16, 0, 1'b1, 1'b0});
    vq.push_back('{16'hFC51, 16'hFC51, 1,  9, 1'b1, 1'b0});
    for (int i = 0; i < 6; i++)
      vq.push_back(model(16'($urandom)));

    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0;
      abort[u] = 1'b0;
      gt[u]    = GOOD;
    end
    #3;
    outs_zero(0, "reset_u2");
    outs_zero(1, "reset_u0");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    for (int u = 0; u < 2; u++)
      foreach (vq[i])
        run_sweep(u, vq[i], -1, $sformatf("tbl%0d_u%0d", i, u));

    // start ignored while busy on the zero-settle instance
    run_sweep(1, model(GOOD), 5, "busy_start");

    // abort and start together in IDLE: abort wins
    @(negedge clk) begin start[0] = 1'b1; abort[0] = 1'b1; end
    @(negedge clk) begin start[0] = 1'b0; abort[0] = 1'b0; end
    chk("abort_beats_start", 32'(busy[0]), 32'd0);

    // abort mid-sweep
    gt[0] = GOOD;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    repeat (19) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk) abort[0] = 1'b0;
    chk("abort_idle", 32'({busy[0], done[0], pass[0], stim[0]}),
        32'd0);
    chk("abort_partial", 32'(sig[0] != 16'd0), 32'd1);
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done[0] || busy[0]) ok = 1'b0;
    end
    chk("abort_no_done", 32'(ok), 32'd1);
    run_sweep(0, model(GOOD), -1, "post_abort");

    // asynchronous reset mid-sweep
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_reset_busy", 32'(busy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    outs_zero(0, "async_reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_sweep(0, model(16'hFC51), -1, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
